// File: rtl/dac_cfg_pkg.sv
// Shared state encoding, default timing constants and timer sizing for the
// DAC configuration supervisor.
package dac_cfg_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_PWRUP    = 3'd0;
   localparam state_t S_TRIG     = 3'd1;
   localparam state_t S_WAIT_CFG = 3'd2;
   localparam state_t S_SETTLE   = 3'd3;
   localparam state_t S_MONITOR  = 3'd4;
   localparam state_t S_FAULT    = 3'd5;

   localparam int unsigned PWRUP_CYC_DEF    = 120000;
   localparam int unsigned CFG_TIME_CYC_DEF = 65536;
   localparam int unsigned SETTLE_CYC_DEF   = 12000;
   localparam int unsigned IRQ_DEBOUNCE_DEF = 16;
   localparam int unsigned MAX_RETRY_DEF    = 3;
   localparam int unsigned RETRY_W_DEF      = 4;

   function automatic int unsigned tmr_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/dac_cfg_supervisor_irq.sv
// Two-flop synchroniser and debounce for the DAC open-drain interrupt;
// emits one registered irq_evt per qualified low episode while enabled.
module dac_irq_sync_debounce #(
   parameter int unsigned IRQ_DEBOUNCE = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_irq_n,
   input  logic i_en,
   output logic o_irq_evt
);

   localparam int unsigned CW = $clog2(IRQ_DEBOUNCE + 1);

   logic          r_sync1;
   logic          r_sync2;
   logic [CW-1:0] r_cnt;
   logic          r_evt;

   // Count parks one above the qualify value so the event fires once per episode.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_cnt   <= '0;
         r_evt   <= 1'b0;
      end else begin
         r_sync1 <= i_irq_n;
         r_sync2 <= r_sync1;
         r_evt   <= i_en && !r_sync2 && (r_cnt == CW'(IRQ_DEBOUNCE - 1));
         if (!i_en || r_sync2)
            r_cnt <= '0;
         else if (r_cnt != CW'(IRQ_DEBOUNCE))
            r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_irq_evt = r_evt;

endmodule

// File: rtl/dac_cfg_supervisor.sv
// Sequences DAC register download triggers with power-up hold-off, config
// window, settle time and IRQ-driven retries up to a fault.
//
// state    | meaning
// PWRUP    | hold-off after reset before the first trigger
// TRIG     | one-cycle dac_parm_set pulse
// WAIT_CFG | download window, IRQ masked
// SETTLE   | post-download settle, IRQ masked
// MONITOR  | configuration valid, watching IRQ
// FAULT    | retry limit exhausted, waiting for cfg_req
module dac_cfg_supervisor
   import dac_cfg_pkg::*;
#(
   parameter int unsigned PWRUP_CYC    = PWRUP_CYC_DEF,
   parameter int unsigned CFG_TIME_CYC = CFG_TIME_CYC_DEF,
   parameter int unsigned SETTLE_CYC   = SETTLE_CYC_DEF,
   parameter int unsigned IRQ_DEBOUNCE = IRQ_DEBOUNCE_DEF,
   parameter int unsigned MAX_RETRY    = MAX_RETRY_DEF,
   parameter int unsigned RETRY_W      = RETRY_W_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_cfg_req,
   input  logic               i_dac_irq_n,
   output logic               o_dac_parm_set,
   output logic               o_cfg_done,
   output logic               o_cfg_fault,
   output logic [RETRY_W-1:0] o_retry_cnt,
   output logic [15:0]        o_cfg_count,
   output logic [2:0]         o_state
);

   localparam int unsigned TW = tmr_width(PWRUP_CYC, CFG_TIME_CYC, SETTLE_CYC);

   // The reset cycle already counts as the first PWRUP cycle.
   localparam logic [TW-1:0] PWR_LD  = (PWRUP_CYC >= 2) ? TW'(PWRUP_CYC - 2) : '0;
   localparam logic [TW-1:0] CFG_LD  = TW'(CFG_TIME_CYC - 1);
   localparam logic [TW-1:0] SETL_LD = TW'(SETTLE_CYC - 1);

   state_t             r_state;
   state_t             w_nxt;
   logic [TW-1:0]      r_tmr;
   logic               r_pwr_arm;
   logic               r_pend;
   logic               r_parm;
   logic [RETRY_W-1:0] r_retry;
   logic [15:0]        r_count;
   logic               w_irq_evt;
   logic               w_exp;
   logic               w_exp_pwr;
   logic               w_retry_clr;
   logic               w_retry_inc;
   logic               w_req_pends;

   dac_irq_sync_debounce #(.IRQ_DEBOUNCE(IRQ_DEBOUNCE)) u_irq (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_irq_n   (i_dac_irq_n),
      .i_en      (r_state == S_MONITOR),
      .o_irq_evt (w_irq_evt)
   );

   assign w_exp       = (r_tmr == '0);
   assign w_exp_pwr   = r_pwr_arm ? w_exp : (PWRUP_CYC <= 1);
   assign w_req_pends = (r_state == S_PWRUP) || (r_state == S_TRIG) ||
                        (r_state == S_WAIT_CFG) || (r_state == S_SETTLE);

   always_comb begin
      w_nxt       = r_state;
      w_retry_clr = 1'b0;
      w_retry_inc = 1'b0;
      case (r_state)
         S_PWRUP:    if (w_exp_pwr) w_nxt = S_TRIG;
         S_TRIG:     w_nxt = S_WAIT_CFG;
         S_WAIT_CFG: if (w_exp) w_nxt = r_pend ? S_TRIG : S_SETTLE;
         S_SETTLE:   if (w_exp) w_nxt = r_pend ? S_TRIG : S_MONITOR;
         S_MONITOR: begin
            if (i_cfg_req) begin
               w_nxt       = S_TRIG;
               w_retry_clr = 1'b1;
            end else if (w_irq_evt) begin
               if (r_retry == RETRY_W'(MAX_RETRY)) begin
                  w_nxt = S_FAULT;
               end else begin
                  w_nxt       = S_TRIG;
                  w_retry_inc = 1'b1;
               end
            end
         end
         S_FAULT: begin
            if (i_cfg_req) begin
               w_nxt       = S_TRIG;
               w_retry_clr = 1'b1;
            end
         end
         default:    w_nxt = S_PWRUP;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_PWRUP;
         r_tmr     <= '0;
         r_pwr_arm <= 1'b0;
         r_pend    <= 1'b0;
         r_parm    <= 1'b0;
         r_retry   <= '0;
         r_count   <= '0;
      end else begin
         r_state <= w_nxt;
         r_parm  <= (w_nxt == S_TRIG);

         if (w_nxt == S_TRIG)
            r_pend <= 1'b0;
         else if (i_cfg_req && w_req_pends)
            r_pend <= 1'b1;

         if ((w_nxt == S_TRIG) && (r_count != 16'hFFFF))
            r_count <= r_count + 16'd1;

         if (w_retry_clr)
            r_retry <= '0;
         else if (w_retry_inc)
            r_retry <= r_retry + RETRY_W'(1);

         if ((r_state == S_PWRUP) && !r_pwr_arm) begin
            r_tmr     <= PWR_LD;
            r_pwr_arm <= 1'b1;
         end else if (w_nxt != r_state) begin
            case (w_nxt)
               S_WAIT_CFG: r_tmr <= CFG_LD;
               S_SETTLE:   r_tmr <= SETL_LD;
               default:    r_tmr <= '0;
            endcase
         end else if (!w_exp) begin
            r_tmr <= r_tmr - TW'(1);
         end
      end
   end

   assign o_dac_parm_set = r_parm;
   assign o_cfg_done     = (r_state == S_MONITOR);
   assign o_cfg_fault    = (r_state == S_FAULT);
   assign o_retry_cnt    = r_retry;
   assign o_cfg_count    = r_count;
   assign o_state        = r_state;

endmodule
